// File: rtl/sc_backg_speedcounter_pkg.sv
// sc_backg_speedcounter_pkg: state codes, selection codes and threshold helper shared by the background lane
package sc_backg_speedcounter_pkg;
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COUNT   = 2'd1,
    REQUEST = 2'd2
  } state_t;
  localparam logic [1:0] SEL_SHIFT = 2'b10;
  localparam logic [1:0] SEL_HOLD  = 2'b11;
  function automatic logic [31:0] thr_of(input logic [31:0] base, input logic [31:0] level);
    return base >> level;
  endfunction
endpackage

// File: rtl/sc_backg_speedcounter_if.sv
// sc_backg_speedcounter_if: strobe/selection/movement handshake between the background state machine and its pacer
interface sc_backg_speedcounter_if;
  logic       SC_BACKG_SPEEDCOUNTER_upcount_InLow;
  logic [1:0] SC_BACKG_SPEEDCOUNTER_shiftselection_InBus;
  logic       SC_BACKG_SPEEDCOUNTER_movement_OutLow;
  modport master (
    output SC_BACKG_SPEEDCOUNTER_upcount_InLow,
    output SC_BACKG_SPEEDCOUNTER_shiftselection_InBus,
    input  SC_BACKG_SPEEDCOUNTER_movement_OutLow
  );
  modport slave (
    input  SC_BACKG_SPEEDCOUNTER_upcount_InLow,
    input  SC_BACKG_SPEEDCOUNTER_shiftselection_InBus,
    output SC_BACKG_SPEEDCOUNTER_movement_OutLow
  );
endinterface

// File: rtl/sc_backg_periodcounter.sv
// sc_backg_periodcounter: strobe counter that wraps to 0 on reaching threshold-1 and flags that cycle as terminal
module sc_backg_periodcounter #(
  parameter int COUNT_WIDTH = 24
) (
  input  logic                   SC_BACKG_PERIODCOUNTER_CLOCK_50,
  input  logic                   SC_BACKG_PERIODCOUNTER_RESET_InLow,
  input  logic                   SC_BACKG_PERIODCOUNTER_clear_InHigh,
  input  logic                   SC_BACKG_PERIODCOUNTER_enable_InHigh,
  input  logic [COUNT_WIDTH-1:0] SC_BACKG_PERIODCOUNTER_threshold_InBus,
  output logic [COUNT_WIDTH-1:0] SC_BACKG_PERIODCOUNTER_count_OutBus,
  output logic                   SC_BACKG_PERIODCOUNTER_terminal_OutHigh
);
  logic [COUNT_WIDTH-1:0] count;
  assign SC_BACKG_PERIODCOUNTER_count_OutBus = count;
  assign SC_BACKG_PERIODCOUNTER_terminal_OutHigh = !SC_BACKG_PERIODCOUNTER_clear_InHigh
    && SC_BACKG_PERIODCOUNTER_enable_InHigh
    && (count >= SC_BACKG_PERIODCOUNTER_threshold_InBus - COUNT_WIDTH'(1));
  // ">=" lets a count left above a freshly lowered threshold terminate on the next strobe
  always_ff @(posedge SC_BACKG_PERIODCOUNTER_CLOCK_50 or negedge SC_BACKG_PERIODCOUNTER_RESET_InLow)
    if (!SC_BACKG_PERIODCOUNTER_RESET_InLow) count <= '0;
    else count <= (SC_BACKG_PERIODCOUNTER_clear_InHigh || SC_BACKG_PERIODCOUNTER_terminal_OutHigh) ? '0
                : SC_BACKG_PERIODCOUNTER_enable_InHigh ? count + COUNT_WIDTH'(1) : count;
endmodule

// File: rtl/sc_backg_speedcounter.sv
// sc_backg_speedcounter: paces background scrolling by level and raises a movement request until the state machine shifts
module sc_backg_speedcounter
  import sc_backg_speedcounter_pkg::*;
#(
  parameter int                   COUNT_WIDTH = 24,
  parameter logic [COUNT_WIDTH-1:0] BASE_PERIOD = 24'd8_000_000,
  parameter int                   LEVEL_WIDTH = 2,
  parameter int                   MISS_WIDTH  = 4
) (
  input  logic                   SC_BACKG_SPEEDCOUNTER_CLOCK_50,
  input  logic                   SC_BACKG_SPEEDCOUNTER_RESET_InLow,
  input  logic                   SC_BACKG_SPEEDCOUNTER_enable_InHigh,
  input  logic                   SC_BACKG_SPEEDCOUNTER_pause_InLow,
  input  logic [LEVEL_WIDTH-1:0] SC_BACKG_SPEEDCOUNTER_level_InBus,
  sc_backg_speedcounter_if.slave lane,
  output logic [MISS_WIDTH-1:0]  SC_BACKG_SPEEDCOUNTER_missed_OutBus
);
  state_t                 state, state_nxt;
  logic [MISS_WIDTH-1:0]  missed_nxt;
  logic [COUNT_WIDTH-1:0] threshold, count;
  logic                   strobe, clear, terminal, ack;
  assign strobe    = !lane.SC_BACKG_SPEEDCOUNTER_upcount_InLow && SC_BACKG_SPEEDCOUNTER_pause_InLow;
  assign clear     = (state == IDLE) || !SC_BACKG_SPEEDCOUNTER_enable_InHigh;
  assign ack       = lane.SC_BACKG_SPEEDCOUNTER_shiftselection_InBus == SEL_SHIFT;
  assign threshold = COUNT_WIDTH'(thr_of(32'(BASE_PERIOD), 32'(SC_BACKG_SPEEDCOUNTER_level_InBus)));
  sc_backg_periodcounter #(.COUNT_WIDTH(COUNT_WIDTH)) u_periodcounter (
    .SC_BACKG_PERIODCOUNTER_CLOCK_50        (SC_BACKG_SPEEDCOUNTER_CLOCK_50),
    .SC_BACKG_PERIODCOUNTER_RESET_InLow     (SC_BACKG_SPEEDCOUNTER_RESET_InLow),
    .SC_BACKG_PERIODCOUNTER_clear_InHigh    (clear),
    .SC_BACKG_PERIODCOUNTER_enable_InHigh   (strobe),
    .SC_BACKG_PERIODCOUNTER_threshold_InBus (threshold),
    .SC_BACKG_PERIODCOUNTER_count_OutBus    (count),
    .SC_BACKG_PERIODCOUNTER_terminal_OutHigh(terminal)
  );
  // next state and miss count; counting keeps running in REQUEST so the period never drifts
  always_comb begin
    state_nxt  = state;
    missed_nxt = SC_BACKG_SPEEDCOUNTER_missed_OutBus;
    if (!SC_BACKG_SPEEDCOUNTER_enable_InHigh) state_nxt = IDLE;
    else begin
      unique case (state)
        IDLE:    state_nxt = COUNT;
        COUNT:   state_nxt = terminal ? REQUEST : COUNT;
        REQUEST: begin
          state_nxt = (terminal || !ack) ? REQUEST : COUNT;
          if (terminal && !ack && SC_BACKG_SPEEDCOUNTER_missed_OutBus != '1)
            missed_nxt = SC_BACKG_SPEEDCOUNTER_missed_OutBus + MISS_WIDTH'(1);
        end
        default: state_nxt = IDLE;
      endcase
    end
  end
  // state and Moore output registers
  always_ff @(posedge SC_BACKG_SPEEDCOUNTER_CLOCK_50 or negedge SC_BACKG_SPEEDCOUNTER_RESET_InLow)
    if (!SC_BACKG_SPEEDCOUNTER_RESET_InLow) begin
      state                                  <= IDLE;
      lane.SC_BACKG_SPEEDCOUNTER_movement_OutLow <= 1'b1;
      SC_BACKG_SPEEDCOUNTER_missed_OutBus    <= '0;
    end else begin
      state                                  <= state_nxt;
      lane.SC_BACKG_SPEEDCOUNTER_movement_OutLow <= state_nxt != REQUEST;
      SC_BACKG_SPEEDCOUNTER_missed_OutBus    <= missed_nxt;
    end
endmodule

// File: tb/tb_sc_backg_speedcounter.sv
// tb_sc_backg_speedcounter: randomized and directed checks of the speed counter against a cycle-level behavioural model
module tb_sc_backg_speedcounter;
  localparam int BASE = 16;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       pause = 1'b1;
  logic [1:0] lvl = 2'd0;
  logic [3:0] miss;
  logic       mov;
  int         vectors = 0;
  int         errors = 0;
  int         m_cnt = 0;
  int         m_miss = 0;
  bit         m_run = 0;
  bit         m_req = 0;
  sc_backg_speedcounter_if lane();
  sc_backg_speedcounter #(.COUNT_WIDTH(24), .BASE_PERIOD(24'(BASE)), .LEVEL_WIDTH(2), .MISS_WIDTH(4)) dut (
    .SC_BACKG_SPEEDCOUNTER_CLOCK_50     (clk),
    .SC_BACKG_SPEEDCOUNTER_RESET_InLow  (rst_n),
    .SC_BACKG_SPEEDCOUNTER_enable_InHigh(en),
    .SC_BACKG_SPEEDCOUNTER_pause_InLow  (pause),
    .SC_BACKG_SPEEDCOUNTER_level_InBus  (lvl),
    .lane                               (lane),
    .SC_BACKG_SPEEDCOUNTER_missed_OutBus(miss)
  );
  assign mov = lane.SC_BACKG_SPEEDCOUNTER_movement_OutLow;
  always #5 clk = ~clk;

  // one clock: drive inputs, step the model with the pre-edge inputs, settle 1ns after the edge
  task automatic cyc(input logic up, input logic [1:0] sel);
    bit strobe, term, ack;
    lane.SC_BACKG_SPEEDCOUNTER_upcount_InLow = up;
    lane.SC_BACKG_SPEEDCOUNTER_shiftselection_InBus = sel;
    @(posedge clk);
    if (!rst_n) begin
      m_run = 0; m_req = 0; m_cnt = 0; m_miss = 0;
    end else if (!en) begin
      m_run = 0; m_req = 0; m_cnt = 0;
    end else if (!m_run) m_run = 1;
    else begin
      strobe = !up && pause;
      term   = strobe && (m_cnt >= (BASE >> lvl) - 1);
      ack    = sel == 2'b10;
      m_cnt  = term ? 0 : strobe ? m_cnt + 1 : m_cnt;
      if (m_req && term && !ack && m_miss < 15) m_miss++;
      m_req  = m_req ? (term || !ack) : term;
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 0; en = 1; lvl = 0; pause = 1;
    for (int i = 0; i < 3; i++) begin
      cyc(0, 2'b11);
      vectors++;
      if (mov !== 1'b1 || miss !== 4'd0) begin
        errors++; $display("FAIL reset_hold: mov=%b miss=%0d want mov=1 miss=0", mov, miss);
      end
    end
    rst_n = 1;
    for (int i = 1; i <= 17; i++) begin
      cyc(0, 2'b11);
      vectors++;
      if (mov !== (i < 17) || mov !== !m_req || miss !== 4'd0) begin
        errors++; $display("FAIL reset_first_request cycle %0d: mov=%b miss=%0d want mov=%b miss=0", i, mov, miss, i < 17);
      end
    end
  endtask

  task automatic test_ack();
    cyc(0, 2'b10);
    vectors++;
    if (mov !== 1'b1) begin
      errors++; $display("FAIL ack_release: mov=%b want 1", mov);
    end
    for (int i = 1; i <= 15; i++) begin
      cyc(0, (i % 3 == 0) ? 2'b11 : (i % 3 == 1) ? 2'b00 : 2'b01);
      vectors++;
      if (mov !== (i < 15) || mov !== !m_req) begin
        errors++; $display("FAIL ack_period strobe %0d: mov=%b want %b", i + 1, mov, i < 15);
      end
    end
    cyc(0, 2'b10);
  endtask

  task automatic test_level();
    lvl = 2;
    for (int i = 0; i < 16; i++) begin
      cyc(0, mov ? 2'b11 : 2'b10);
      vectors++;
      if (mov !== !m_req || miss !== 4'(m_miss)) begin
        errors++; $display("FAIL level2 cycle %0d: mov=%b miss=%0d want mov=%b miss=%0d", i, mov, miss, !m_req, m_miss);
      end
    end
    en = 0; cyc(1, 2'b11);
    en = 1; lvl = 0; cyc(1, 2'b11);
    for (int i = 0; i < 40 && m_cnt != 9; i++) cyc(0, 2'b11);
    vectors++;
    if (m_cnt != 9 || mov !== 1'b1) begin
      errors++; $display("FAIL level_setup: model count %0d mov=%b want count 9 mov=1", m_cnt, mov);
    end
    lvl = 3;
    cyc(0, 2'b11);
    vectors++;
    if (mov !== 1'b0 || mov !== !m_req) begin
      errors++; $display("FAIL level_drop_terminal: mov=%b want 0", mov);
    end
  endtask

  task automatic test_overrun();
    lvl = 2;
    for (int i = 1; i <= 40; i++) begin
      cyc(0, 2'b11);
      vectors++;
      if (mov !== 1'b0 || miss !== 4'(m_miss)) begin
        errors++; $display("FAIL overrun strobe %0d: mov=%b miss=%0d want mov=0 miss=%0d", i, mov, miss, m_miss);
      end
    end
    vectors++;
    if (miss !== 4'd10) begin
      errors++; $display("FAIL overrun_ten: miss=%0d want 10", miss);
    end
    for (int i = 0; i < 40; i++) cyc(0, (i % 2) ? 2'b01 : 2'b11);
    vectors++;
    if (miss !== 4'd15 || mov !== 1'b0) begin
      errors++; $display("FAIL overrun_saturate: miss=%0d mov=%b want miss=15 mov=0", miss, mov);
    end
  endtask

  task automatic test_pause();
    lvl = 0;
    cyc(1, 2'b10);
    for (int i = 0; i < 5; i++) cyc(0, 2'b11);
    pause = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(0, 2'b11);
      vectors++;
      if (mov !== 1'b1 || m_cnt != 5) begin
        errors++; $display("FAIL pause_freeze cycle %0d: mov=%b want 1", i, mov);
      end
    end
    pause = 1;
    for (int i = 0; i < 11; i++) cyc(0, 2'b11);
    vectors++;
    if (mov !== 1'b0) begin
      errors++; $display("FAIL pause_resume_period: mov=%b want 0 after 16 strobes", mov);
    end
    pause = 0;
    for (int i = 0; i < 6; i++) begin
      cyc(0, 2'b11);
      vectors++;
      if (mov !== 1'b0) begin
        errors++; $display("FAIL pause_hold_request cycle %0d: mov=%b want 0", i, mov);
      end
    end
    cyc(0, 2'b10);
    vectors++;
    if (mov !== 1'b1 || mov !== !m_req) begin
      errors++; $display("FAIL pause_ack: mov=%b want 1", mov);
    end
    pause = 1;
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 40 && !m_req; i++) cyc(0, 2'b11);
    vectors++;
    if (mov !== 1'b0) begin
      errors++; $display("FAIL async_setup: mov=%b want 0", mov);
    end
    #2 rst_n = 0;
    #1;
    m_run = 0; m_req = 0; m_cnt = 0; m_miss = 0;
    vectors++;
    if (mov !== 1'b1 || miss !== 4'd0) begin
      errors++; $display("FAIL async_reset: mov=%b miss=%0d want mov=1 miss=0", mov, miss);
    end
    #1 rst_n = 1;
    for (int i = 1; i <= 17; i++) begin
      cyc(0, 2'b11);
      vectors++;
      if (mov !== (i < 17)) begin
        errors++; $display("FAIL async_restart cycle %0d: mov=%b want %b", i, mov, i < 17);
      end
    end
  endtask

  task automatic test_enable_drop();
    vectors++;
    if (mov !== 1'b0) begin
      errors++; $display("FAIL enable_setup: mov=%b want 0", mov);
    end
    en = 0;
    cyc(0, 2'b11);
    vectors++;
    if (mov !== 1'b1 || mov !== !m_req) begin
      errors++; $display("FAIL enable_drop: mov=%b want 1", mov);
    end
    en = 1;
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      en    = ($urandom_range(0, 49) != 0);
      pause = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 29) == 0) lvl = 2'($urandom_range(0, 3));
      cyc(1'($urandom_range(0, 3) != 0 ? 0 : 1), 2'($urandom_range(0, 3)));
      vectors++;
      if (mov !== !m_req || miss !== 4'(m_miss)) begin
        errors++; $display("FAIL random cycle %0d: mov=%b miss=%0d want mov=%b miss=%0d", i, mov, miss, !m_req, m_miss);
      end
    end
  endtask

  initial begin
    lane.SC_BACKG_SPEEDCOUNTER_upcount_InLow = 1'b1;
    lane.SC_BACKG_SPEEDCOUNTER_shiftselection_InBus = 2'b11;
    test_reset();
    test_ack();
    test_level();
    test_overrun();
    test_pause();
    test_async_reset();
    test_enable_drop();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
